// File: rtl/alu_issue_seq.sv
// Issue sequencer in front of the 16-bit ripple ALU: decodes the function onto the
// ALU controls, holds operands while the carry chain settles, adds SLT and shifts.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// EXEC  | operands held on the ALU, wait counter running
// SHIFT | shifting one bit per cycle, ALU untouched
// DONE  | result held until the consumer takes it
module alu_issue_seq #(
    parameter int DATA_W   = 16,
    parameter int ALU_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fn,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_ainvert,
    output logic              alu_bnegate,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res,
    output logic              res_cout,
    output logic              res_ovf,
    output logic              res_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    localparam logic [2:0] FN_AND = 3'd0;
    localparam logic [2:0] FN_OR  = 3'd1;
    localparam logic [2:0] FN_ADD = 3'd2;
    localparam logic [2:0] FN_SUB = 3'd3;
    localparam logic [2:0] FN_NOR = 3'd4;
    localparam logic [2:0] FN_SLT = 3'd5;
    localparam logic [2:0] FN_SLL = 3'd6;
    localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

    state_t            state, state_nxt;
    logic [2:0]        fn_q;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] sh;
    logic              sh_out;
    logic              cnt_tc;
    logic              is_shift;
    logic              out_fire;

    logic [2:0]        dec_op;
    logic              dec_ainv, dec_bneg, dec_cin;
    logic [DATA_W-1:0] exec_res;
    logic              exec_cout, exec_ovf;

    assign cnt_tc   = (cnt == 4'd0);
    assign is_shift = (in_fn[2:1] == 2'b11);
    assign out_fire = out_valid && out_ready;
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = is_shift ? SHIFT : EXEC;
            EXEC:    if (cnt_tc) state_nxt = DONE;
            SHIFT:   if (cnt_tc) state_nxt = DONE;
            DONE:    if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOR is built as (~a & ~b) on the AND path
    always_comb begin
        dec_op   = 3'b000;
        dec_ainv = 1'b0;
        dec_bneg = 1'b0;
        dec_cin  = 1'b0;
        case (in_fn)
            FN_AND: dec_op = 3'b000;
            FN_OR:  dec_op = 3'b001;
            FN_ADD: dec_op = 3'b010;
            FN_SUB, FN_SLT: begin
                dec_op   = 3'b010;
                dec_bneg = 1'b1;
                dec_cin  = 1'b1;
            end
            FN_NOR: begin
                dec_ainv = 1'b1;
                dec_bneg = 1'b1;
            end
            default: dec_op = 3'b000;
        endcase
    end

    always_comb begin
        exec_res  = alu_result;
        exec_cout = 1'b0;
        exec_ovf  = 1'b0;
        case (fn_q)
            FN_ADD, FN_SUB: begin
                exec_cout = alu_cout;
                exec_ovf  = alu_overflow;
            end
            FN_SLT: begin
                exec_res  = {{(DATA_W-1){1'b0}}, alu_result[DATA_W-1] ^ alu_overflow};
                exec_cout = alu_cout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fn_q        <= 3'd0;
            cnt         <= 4'd0;
            sh          <= '0;
            sh_out      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 3'b000;
            alu_ainvert <= 1'b0;
            alu_bnegate <= 1'b0;
            alu_cin     <= 1'b0;
            out_valid   <= 1'b0;
            res         <= '0;
            res_cout    <= 1'b0;
            res_ovf     <= 1'b0;
            res_zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    fn_q <= in_fn;
                    if (is_shift) begin
                        sh     <= in_a;
                        cnt    <= in_b[3:0];
                        sh_out <= 1'b0;
                    end else begin
                        alu_a       <= in_a;
                        alu_b       <= in_b;
                        alu_op      <= dec_op;
                        alu_ainvert <= dec_ainv;
                        alu_bnegate <= dec_bneg;
                        alu_cin     <= dec_cin;
                        cnt         <= WAIT_LOAD;
                    end
                end
                EXEC: begin
                    if (cnt_tc) begin
                        res       <= exec_res;
                        res_cout  <= exec_cout;
                        res_ovf   <= exec_ovf;
                        res_zero  <= (exec_res == '0);
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_tc) begin
                        res       <= sh;
                        res_cout  <= sh_out;
                        res_ovf   <= 1'b0;
                        res_zero  <= (sh == '0);
                        out_valid <= 1'b1;
                    end else begin
                        if (fn_q == FN_SLL) begin
                            sh     <= sh << 1;
                            sh_out <= sh[DATA_W-1];
                        end else begin
                            sh     <= sh >> 1;
                            sh_out <= sh[0];
                        end
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: if (out_fire) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: two instances (ALU_WAIT 1 and 4), each fed by a
// behavioural 16-bit ALU; expected results are hand-computed constants.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // instance with ALU_WAIT=1
    logic        in_valid = 1'b0, in_ready;
    logic [2:0]  in_fn = 3'd0;
    logic [15:0] in_a = 16'h0, in_b = 16'h0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_ainvert, alu_bnegate, alu_cin, alu_cout, alu_overflow;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] res;
    logic        res_cout, res_ovf, res_zero;

    // instance with ALU_WAIT=4
    logic        in_valid4 = 1'b0, in_ready4;
    logic [2:0]  in_fn4 = 3'd0;
    logic [15:0] in_a4 = 16'h0, in_b4 = 16'h0;
    logic [15:0] alu_a4, alu_b4, alu_result4;
    logic [2:0]  alu_op4;
    logic        alu_ainvert4, alu_bnegate4, alu_cin4, alu_cout4, alu_overflow4;
    logic        out_valid4, out_ready4 = 1'b0;
    logic [15:0] res4;
    logic        res_cout4, res_ovf4, res_zero4;

    int n_chk = 0;
    int n_bad = 0;

    function automatic logic [17:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op, input logic ai,
                                              input logic bn, input logic ci);
        logic [15:0] ae, be;
        logic [16:0] s;
        ae = ai ? ~a : a;
        be = bn ? ~b : b;
        s  = {1'b0, ae} + {1'b0, be} + {16'b0, ci};
        case (op)
            3'b000:  return {2'b00, ae & be};
            3'b001:  return {2'b00, ae | be};
            default: return {(ae[15] == be[15]) && (s[15] != ae[15]), s[16], s[15:0]};
        endcase
    endfunction

    assign {alu_overflow, alu_cout, alu_result} =
        alu_model(alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin);
    assign {alu_overflow4, alu_cout4, alu_result4} =
        alu_model(alu_a4, alu_b4, alu_op4, alu_ainvert4, alu_bnegate4, alu_cin4);

    alu_issue_seq #(.DATA_W(16), .ALU_WAIT(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fn(in_fn),
        .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_ainvert(alu_ainvert), .alu_bnegate(alu_bnegate), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .res(res),
        .res_cout(res_cout), .res_ovf(res_ovf), .res_zero(res_zero)
    );

    alu_issue_seq #(.DATA_W(16), .ALU_WAIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_fn(in_fn4),
        .in_a(in_a4), .in_b(in_b4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4),
        .alu_ainvert(alu_ainvert4), .alu_bnegate(alu_bnegate4), .alu_cin(alu_cin4),
        .alu_result(alu_result4), .alu_cout(alu_cout4), .alu_overflow(alu_overflow4),
        .out_valid(out_valid4), .out_ready(out_ready4), .res(res4),
        .res_cout(res_cout4), .res_ovf(res_ovf4), .res_zero(res_zero4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_fn    = fn;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // edges from the accept edge to out_valid; ALU controls must not move meanwhile
    task automatic wait_out(output int lat);
        logic [37:0] snap;
        int          moved;
        snap  = {alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin};
        moved = 0;
        lat   = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if ({alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate, alu_cin} != snap) moved++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("alu_hold", 32'(moved), 32'd0);
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int moved;
        int seen;
        logic [37:0] snap4;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(res), 32'h0);
        chk("rst_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'd0);
        chk("rst_alu", {alu_a, alu_b} , 32'h0);
        chk("rst_ctl", {26'd0, alu_op, alu_ainvert, alu_bnegate, alu_cin}, 32'd0);

        // ADD with signed overflow
        accept(3'd2, 16'h7FFF, 16'h0001);
        chk("add_ctl", {26'd0, alu_op, alu_ainvert, alu_bnegate, alu_cin}, {26'd0, 3'b010, 3'b000});
        chk("add_busy", 32'(in_ready), 32'd0);
        wait_out(lat);
        chk("add_lat", 32'(lat), 32'd1);
        chk("add_res", 32'(res), 32'h8000);
        chk("add_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'b010);
        take();

        // SUB equal operands
        accept(3'd3, 16'h0005, 16'h0005);
        chk("sub_ctl", {26'd0, alu_op, alu_ainvert, alu_bnegate, alu_cin}, {26'd0, 3'b010, 3'b011});
        wait_out(lat);
        chk("sub_lat", 32'(lat), 32'd1);
        chk("sub_res", 32'(res), 32'h0000);
        chk("sub_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'b101);
        take();

        // SLT: -32768 < 1, carry from the subtract passes through
        accept(3'd5, 16'h8000, 16'h0001);
        wait_out(lat);
        chk("slt1_res", 32'(res), 32'h0001);
        chk("slt1_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'b100);
        take();

        accept(3'd5, 16'h0001, 16'h8000);
        wait_out(lat);
        chk("slt2_res", 32'(res), 32'h0000);
        chk("slt2_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'b001);
        take();

        accept(3'd0, 16'hF0F0, 16'hFF00);
        wait_out(lat);
        chk("and_res", 32'(res), 32'hF000);
        chk("and_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'b000);
        take();

        accept(3'd1, 16'h1200, 16'h0034);
        chk("or_ctl", {26'd0, alu_op, alu_ainvert, alu_bnegate, alu_cin}, {26'd0, 3'b001, 3'b000});
        wait_out(lat);
        chk("or_res", 32'(res), 32'h1234);
        take();

        accept(3'd4, 16'hF0F0, 16'h0F00);
        chk("nor_ctl", {26'd0, alu_op, alu_ainvert, alu_bnegate, alu_cin}, {26'd0, 3'b000, 3'b110});
        wait_out(lat);
        chk("nor_res", 32'(res), 32'h000F);
        chk("nor_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'b000);
        take();

        // SLL by 3: ALU controls keep the NOR values
        accept(3'd6, 16'hE001, 16'h0003);
        wait_out(lat);
        chk("sll_lat", 32'(lat), 32'd4);
        chk("sll_res", 32'(res), 32'h0008);
        chk("sll_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'b100);
        chk("sll_alu_kept", {alu_a, 10'd0, alu_op, alu_ainvert, alu_bnegate, alu_cin},
            {16'hF0F0, 10'd0, 3'b000, 3'b110});
        take();

        accept(3'd7, 16'h0003, 16'h0000);
        wait_out(lat);
        chk("srl0_lat", 32'(lat), 32'd1);
        chk("srl0_res", 32'(res), 32'h0003);
        chk("srl0_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'b000);
        take();

        accept(3'd7, 16'h8008, 16'h0004);
        wait_out(lat);
        chk("srl4_lat", 32'(lat), 32'd5);
        chk("srl4_res", 32'(res), 32'h0800);
        chk("srl4_flags", {29'd0, res_cout, res_ovf, res_zero}, 32'b100);
        take();

        // Backpressure with a new request pending
        accept(3'd2, 16'h0001, 16'h0002);
        wait_out(lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_fn    = 3'd1;
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        moved    = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || res != 16'h0003 || res_cout || res_ovf || res_zero || in_ready)
                moved++;
        end
        chk("bp_hold", 32'(moved), 32'd0);
        chk("bp_no_accept", 32'(alu_a), 32'h0001);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset on the third shift edge of a 15-bit SLL
        accept(3'd6, 16'h0001, 16'h000F);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_state", {30'd0, in_ready, out_valid}, 32'b10);
        chk("mid_rst_res", 32'(res), 32'h0000);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_out", 32'(seen), 32'd0);

        // ALU_WAIT=4 instance: SUB 5-5
        @(negedge clk);
        in_valid4 = 1'b1;
        in_fn4    = 3'd3;
        in_a4     = 16'h0005;
        in_b4     = 16'h0005;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        snap4 = {alu_a4, alu_b4, alu_op4, alu_ainvert4, alu_bnegate4, alu_cin4};
        chk("w4_ctl", {26'd0, alu_op4, alu_ainvert4, alu_bnegate4, alu_cin4}, {26'd0, 3'b010, 3'b011});
        lat   = 0;
        moved = 0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if ({alu_a4, alu_b4, alu_op4, alu_ainvert4, alu_bnegate4, alu_cin4} != snap4) moved++;
        end
        chk("w4_lat", 32'(lat), 32'd4);
        chk("w4_hold", 32'(moved), 32'd0);
        chk("w4_res", 32'(res4), 32'h0000);
        chk("w4_flags", {29'd0, res_cout4, res_ovf4, res_zero4}, 32'b101);
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        chk("w4_release", {30'd0, out_valid4, in_ready4}, 32'b01);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
